alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle controller wrapping a 4-bit ALU datapath with a small register file.
//  Accepts one command at a time over a valid/ready port, reads operands, executes and
//  writes back. Returns result plus flags over a valid/ready response port.
//  Lab-level CPU building block; sits between a command source (testbench/decoder) and the ALU.
// PARAMETERS
//  DATA_W   4   operand/result width
//  NREGS    4   register file depth
//  ADDR_W   2   register address width, clog2(NREGS)
//  CNT_W    8   completed-operation counter width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        sequencer can accept command
//  cmd_ld     in   1        1 = load immediate into rd, 0 = ALU op
//  cmd_op     in   3        ALU op: 000 ADD,001 SUB,010 XOR,011 OR,100 AND,101 NOR,110 NAND,111 XNOR
//  cmd_rd     in   ADDR_W   destination register
//  cmd_rs1    in   ADDR_W   source A
//  cmd_rs2    in   ADDR_W   source B
//  cmd_imm    in   DATA_W   immediate (cmd_ld=1 only)
//  rsp_valid  out  1        result available
//  rsp_ready  in   1        consumer takes result
//  rsp_data   out  DATA_W   value written to rd
//  rsp_zero   out  1        rsp_data == 0
//  rsp_carry  out  1        ADD carry-out / SUB borrow; 0 for logic ops and loads
//  dbg_addr   in   ADDR_W   debug read address
//  dbg_data   out  DATA_W   combinational read of reg[dbg_addr]
//  op_count   out  CNT_W    number of completed responses, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, all regs=0, cmd_ready=1 (after reset), rsp_valid=0,
//   rsp_data/zero/carry=0, op_count=0. Reset mid-operation aborts it; no writeback occurs.
//  FSM (registered state, Moore outputs):
//   IDLE : cmd_ready=1. cmd_valid -> latch cmd fields, go READ.
//   READ : latch A=reg[rs1], B=reg[rs2] (or imm for load) -> EXEC.
//   EXEC : compute DATA_W+1-bit result; register result/flags -> WB.
//   WB   : write reg[rd]; rsp_valid=1; hold all rsp_* stable until rsp_ready.
//          rsp_ready=1 -> op_count++, go IDLE.
//  Latency: cmd accepted at edge T -> rsp_valid high from T+3. Max throughput 1 cmd/4 cycles.
//  cmd_ready=0 outside IDLE; cmd fields ignored there. No bypass: a new command is not
//   accepted in the cycle WB completes, only from the next IDLE cycle.
//  Arithmetic: ADD = {carry,sum} = A+B (unsigned, mod 2^DATA_W); SUB = A-B, carry=1 if A<B.
//   Logic ops bitwise, carry=0. Load: result=imm, carry=0. zero computed on DATA_W result.
//  Hazards: rs1/rs2 equal to rd read the pre-write value; writeback visible to next cmd's READ.
//  Register write occurs once, on WB entry edge; back-pressure in WB does not rewrite.
//  dbg_data reflects writes the cycle after the write edge.
// STRUCTURE
//  Package alu_seq_pkg: op encoding localparams (OP_ADD..OP_XNOR), state enum
//   (S_IDLE,S_READ,S_EXEC,S_WB), DATA_W/ADDR_W defaults.
//  Sub-module alu_exec: combinational, (a,b,op) -> {carry,result}; all 8 ops defined,
//   no X outputs. Sequencer owns FSM, regfile, response regs, counter.
// TESTING
//  1 Load imm 4'hF->r0, 4'h1->r1; ADD r2=r0+r1 -> rsp_data=0, zero=1, carry=1, rsp at T+3.
//  2 SUB r3=r1-r0 (1-15) -> rsp_data=4'h2, carry=1; SUB r3=r0-r1 -> 4'hE, carry=0.
//  3 All 8 ops on A=4'hA,B=4'h6: ADD 0,SUB 4,XOR C,OR E,AND 2,NOR 1,NAND D,XNOR 3.
//  4 Hold rsp_ready=0 10 cycles -> rsp_* stable, cmd_ready=0, reg written once, op_count +1 only.
//  5 Assert rst during EXEC of load 4'h7->r2 -> r2 stays 0, rsp_valid never rises, op_count=0.
//  6 256 back-to-back commands with rsp_ready=1 -> op_count wraps to 0, 4-cycle cadence held.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: sizes, op encodings, FSM states.
package alu_seq_pkg;

   localparam int DEFAULT_DATA_W = 4;
   localparam int DEFAULT_NREGS  = 4;
   localparam int DEFAULT_ADDR_W = 2;
   localparam int DEFAULT_CNT_W  = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_NAND = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } state_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: computes a DATA_W+1 bit result whose MSB is the ADD carry
// or SUB borrow; logic ops always leave the MSB clear.
module alu_exec
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              carry
);

   logic [DATA_W:0] wide;

   // Evaluate the selected operation; zero-extending before SUB makes the MSB the borrow.
   always_comb begin
      wide = '0;
      case (op)
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};
         OP_XOR:  wide = {1'b0, a ^ b};
         OP_OR:   wide = {1'b0, a | b};
         OP_AND:  wide = {1'b0, a & b};
         OP_NOR:  wide = {1'b0, ~(a | b)};
         OP_NAND: wide = {1'b0, ~(a & b)};
         OP_XNOR: wide = {1'b0, ~(a ^ b)};
         default: wide = '0;
      endcase
   end

   assign result = wide[DATA_W-1:0];
   assign carry  = wide[DATA_W];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state command sequencer around alu_exec: accepts one command, reads the
// register file, executes, writes back once and holds the response until taken.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NREGS  = DEFAULT_NREGS,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_ld,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic              rsp_carry,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  op_count
);

   state_e state_q, state_d;

   // Latched command fields
   logic              ld_q,  ld_d;
   logic [2:0]        op_q,  op_d;
   logic [ADDR_W-1:0] rd_q,  rd_d;
   logic [ADDR_W-1:0] rs1_q, rs1_d;
   logic [ADDR_W-1:0] rs2_q, rs2_d;
   logic [DATA_W-1:0] imm_q, imm_d;

   // Operands captured in READ; for loads b carries the immediate
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;

   // Response registers and statistics
   logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
   logic              rsp_zero_q,  rsp_zero_d;
   logic              rsp_carry_q, rsp_carry_d;
   logic [CNT_W-1:0]  op_count_q,  op_count_d;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic [DATA_W-1:0] exec_result;
   logic              exec_carry;

   alu_exec #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Loads bypass the ALU and never report a carry
   assign exec_result = ld_q ? b_q : alu_result;
   assign exec_carry  = ld_q ? 1'b0 : alu_carry;

   // Next-state logic and Moore handshake outputs
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = S_READ;
         end
         S_READ: state_d = S_EXEC;
         S_EXEC: state_d = S_WB;
         S_WB: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: command latch, operand fetch, single writeback on WB entry, counter
   always_comb begin
      ld_d        = ld_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      imm_d       = imm_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_carry_d = rsp_carry_q;
      op_count_d  = op_count_q;
      regs_d      = regs_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               ld_d  = cmd_ld;
               op_d  = cmd_op;
               rd_d  = cmd_rd;
               rs1_d = cmd_rs1;
               rs2_d = cmd_rs2;
               imm_d = cmd_imm;
            end
         end
         S_READ: begin
            a_d = regs_q[rs1_q];
            b_d = ld_q ? imm_q : regs_q[rs2_q];
         end
         S_EXEC: begin
            rsp_data_d   = exec_result;
            rsp_zero_d   = (exec_result == '0);
            rsp_carry_d  = exec_carry;
            regs_d[rd_q] = exec_result;
         end
         S_WB: begin
            if (rsp_ready) op_count_d = op_count_q + 1'b1;
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ld_q        <= 1'b0;
         op_q        <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_carry_q <= 1'b0;
         op_count_q  <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ld_q        <= ld_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         imm_q       <= imm_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_carry_q <= rsp_carry_d;
         op_count_q  <= op_count_d;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_carry = rsp_carry_q;
   assign op_count  = op_count_q;
   assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, back-pressure and reset
// sequences, then randomized back-to-back commands against a register model.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_ld;
   logic [2:0] cmd_op;
   logic [1:0] cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
   logic [3:0] cmd_imm, rsp_data, dbg_data;
   logic       rsp_valid, rsp_ready, rsp_zero, rsp_carry;
   logic [7:0] op_count;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_ld    (cmd_ld),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_rs1   (cmd_rs1),
      .cmd_rs2   (cmd_rs2),
      .cmd_imm   (cmd_imm),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zero  (rsp_zero),
      .rsp_carry (rsp_carry),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .op_count  (op_count)
   );

   typedef struct {
      logic       ld;
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [3:0] imm;
      logic [3:0] e_data;
      logic       e_zero;
      logic       e_carry;
   } vec_t;

   vec_t vecs [18];

   int tests = 0;
   int fails = 0;

   // Reference state: register contents and completed-response count
   logic [3:0] m_regs [4];
   int         m_count;

   time t_acc, t_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Architectural effect of one command, from the op definitions
   function automatic void model_exec(input logic ld, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] rs1,
                                      input logic [1:0] rs2, input logic [3:0] imm,
                                      output logic [3:0] d, output logic z, output logic c);
      int a, b, r;
      a = int'(m_regs[rs1]);
      b = int'(m_regs[rs2]);
      c = 1'b0;
      if (ld) r = int'(imm);
      else begin
         case (op)
            3'd0: begin r = a + b; c = (r > 15); end
            3'd1: begin r = a - b; c = (a < b);  end
            3'd2: r = a ^ b;
            3'd3: r = a | b;
            3'd4: r = a & b;
            3'd5: r = ~(a | b);
            3'd6: r = ~(a & b);
            default: r = ~(a ^ b);
         endcase
      end
      d = 4'(r & 15);
      z = (d == 4'h0);
      m_regs[rd] = d;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_ld = ld; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("cmd_accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Response must be sampled valid two edges after acceptance (visible at edge T+3)
   task automatic await_rsp(output logic [3:0] d, output logic z, output logic c);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rsp_latency", 32'(n), 32'd2);
      d = rsp_data;
      z = rsp_zero;
      c = rsp_carry;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [1:0] addr, input logic [3:0] exp);
      dbg_addr = addr;
      #1;
      check(name, 32'(dbg_data), 32'(exp));
   endtask

   initial begin
      logic [3:0] d, md;
      logic       z, c, mz, mc;
      logic       r_ld;
      logic [2:0] r_op;
      logic [1:0] r_rd, r_rs1, r_rs2;
      logic [3:0] r_imm;

      vecs[0]  = '{1'b1, OP_ADD,  2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, OP_ADD,  2'd1, 2'd0, 2'd0, 4'h1, 4'h1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, OP_ADD,  2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, OP_SUB,  2'd3, 2'd1, 2'd0, 4'h0, 4'h2, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, OP_SUB,  2'd3, 2'd0, 2'd1, 4'h0, 4'hE, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, OP_ADD,  2'd0, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, OP_ADD,  2'd1, 2'd0, 2'd0, 4'h6, 4'h6, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, OP_ADD,  2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, OP_SUB,  2'd2, 2'd0, 2'd1, 4'h0, 4'h4, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, OP_XOR,  2'd2, 2'd0, 2'd1, 4'h0, 4'hC, 1'b0, 1'b0};
      vecs[10] = '{1'b0, OP_OR,   2'd2, 2'd0, 2'd1, 4'h0, 4'hE, 1'b0, 1'b0};
      vecs[11] = '{1'b0, OP_AND,  2'd2, 2'd0, 2'd1, 4'h0, 4'h2, 1'b0, 1'b0};
      vecs[12] = '{1'b0, OP_NOR,  2'd2, 2'd0, 2'd1, 4'h0, 4'h1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, OP_NAND, 2'd2, 2'd0, 2'd1, 4'h0, 4'hD, 1'b0, 1'b0};
      vecs[14] = '{1'b0, OP_XNOR, 2'd2, 2'd0, 2'd1, 4'h0, 4'h3, 1'b0, 1'b0};
      vecs[15] = '{1'b0, OP_ADD,  2'd1, 2'd1, 2'd1, 4'h0, 4'hC, 1'b0, 1'b0};
      vecs[16] = '{1'b0, OP_SUB,  2'd3, 2'd1, 2'd0, 4'h0, 4'h2, 1'b0, 1'b0};
      vecs[17] = '{1'b1, OP_ADD,  2'd3, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0; cmd_rd = '0;
      cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; rsp_ready = 1'b0; dbg_addr = '0;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
      m_count = 0;
      t_prev = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data",  32'(rsp_data),  32'd0);
      check("reset_rsp_zero",  32'(rsp_zero),  32'd0);
      check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
      check("reset_op_count",  32'(op_count),  32'd0);
      for (int i = 0; i < 4; i++) check_reg("reset_reg", 2'(i), 4'h0);
      @(negedge clk);

      // Directed vectors: loads, ADD/SUB edges, all ops on A/6, hazards
      for (int i = 0; i < 18; i++) begin
         send_cmd(vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
         await_rsp(d, z, c);
         check("vec_data",  32'(d), 32'(vecs[i].e_data));
         check("vec_zero",  32'(z), 32'(vecs[i].e_zero));
         check("vec_carry", 32'(c), 32'(vecs[i].e_carry));
         release_rsp();
         model_exec(vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                    md, mz, mc);
         m_count++;
         check_reg("vec_dbg_reg", vecs[i].rd, vecs[i].e_data);
         @(negedge clk);
      end
      check("vec_op_count", 32'(op_count), 32'd18);

      // Back-pressure: hold rsp_ready low for 10 cycles with a competing command offered
      model_exec(1'b0, OP_ADD, 2'd3, 2'd3, 2'd0, 4'h0, md, mz, mc);
      send_cmd(1'b0, OP_ADD, 2'd3, 2'd3, 2'd0, 4'h0);
      await_rsp(d, z, c);
      check("bp_data", 32'(d), 32'(md));
      check("bp_zero", 32'(z), 32'(mz));
      check("bp_carry", 32'(c), 32'(mc));
      cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 2'd0; cmd_imm = 4'h5;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_rsp_valid_hold", 32'(rsp_valid), 32'd1);
         check("bp_rsp_data_hold",  32'(rsp_data),  32'(md));
         check("bp_rsp_flags_hold", 32'({rsp_zero, rsp_carry}), 32'({mz, mc}));
         check("bp_cmd_ready_low",  32'(cmd_ready), 32'd0);
      end
      check_reg("bp_reg_written", 2'd3, md);
      release_rsp();
      check("bp_idle_after_wb", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      m_count++;
      check("bp_op_count", 32'(op_count), 32'(m_count));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);
      end
      check_reg("bp_r0_untouched", 2'd0, m_regs[0]);
      check("bp_op_count_final", 32'(op_count), 32'(m_count));
      @(negedge clk);

      // Reset while a load of 7 into r2 sits in EXEC
      send_cmd(1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 4'h7);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
      m_count = 0;
      for (int k = 0; k < 6; k++) begin
         check("rst_no_rsp_valid", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_reg("rst_r2_zero", 2'd2, 4'h0);
      check_reg("rst_r0_zero", 2'd0, 4'h0);
      @(negedge clk);

      // 256 randomized back-to-back commands: model compare, cadence, counter wrap
      for (int i = 0; i < 256; i++) begin
         r_ld  = ($urandom_range(0, 3) == 0);
         r_op  = 3'($urandom_range(0, 7));
         r_rd  = 2'($urandom_range(0, 3));
         r_rs1 = 2'($urandom_range(0, 3));
         r_rs2 = 2'($urandom_range(0, 3));
         r_imm = 4'($urandom_range(0, 15));
         model_exec(r_ld, r_op, r_rd, r_rs1, r_rs2, r_imm, md, mz, mc);
         send_cmd(r_ld, r_op, r_rd, r_rs1, r_rs2, r_imm);
         if (i > 0) check("rand_cadence", 32'(t_acc - t_prev), 32'd40);
         t_prev = t_acc;
         await_rsp(d, z, c);
         check("rand_data",  32'(d), 32'(md));
         check("rand_zero",  32'(z), 32'(mz));
         check("rand_carry", 32'(c), 32'(mc));
         release_rsp();
         m_count = (m_count + 1) % 256;
         check("rand_op_count", 32'(op_count), 32'(m_count));
         check_reg("rand_dbg_reg", r_rd, md);
      end
      check("wrap_op_count_zero", 32'(op_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time guard so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
